seg_scan_driver: RTL and testbench
==================================

# seg_scan_driver

Time-multiplexed driver for a 4-digit, common-anode seven-segment display. It sits directly downstream of the adder datapath and accepts a 16-bit hex value plus a carry flag through a load strobe. It scans one digit at a time, driving active-low anode and segment lines. New values are applied only at frame boundaries, so a displayed frame never mixes old and new digits.

## Interface
- REFRESH_DIV, default 100000: clock cycles each digit stays active; legal range 2..2^20.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- value  input  16  four hex nibbles; value[3:0] is digit 0 (rightmost), value[15:12] is digit 3.
- carry  input  1  adder carry-out; lights the decimal point of digit 3.
- load  input  1  single-cycle strobe; captures value and carry.
- seg  output  7  segment lines, active-low, seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, active-low.
- an  output  4  anode enables, active-low, an[k] selects digit k.
- frame_tick  output  1  one-cycle pulse on the last cycle of each frame.

## Operation
- State:
  - prescaler presc, 0..REFRESH_DIV-1
  - digit index dig, 0..3
  - shadow register {sh_val, sh_cy}
  - display register {dsp_val, dsp_cy}
  - pending flag
- Reset: all of the above clear to 0. Registered outputs take an=4'b1111, seg=7'h7F, dp=1, frame_tick=0.
- Prescaler:
  - presc increments every cycle.
  - When presc==REFRESH_DIV-1, presc wraps to 0 and dig advances 0→1→2→3→0.
- Boundary cycle: presc==REFRESH_DIV-1 and dig==3. frame_tick is asserted combinationally from state in exactly this cycle.
- Load outside a boundary cycle: sh_val←value, sh_cy←carry, pending←1. A second load before the boundary overwrites the shadow; only the last value is shown.
- Boundary cycle handling:
  - load=1: dsp←{value, carry} directly, shadow also updated, pending←0.
  - load=0 and pending=1: dsp←shadow, pending←0.
  - Otherwise the display register holds.
- Output registers, updated every cycle from the current dig and dsp:
  - an = ~(4'b0001<<dig)
  - seg = hex pattern of nibble dig
  - dp = ~(dsp_cy & (dig==3))
- Hex patterns {g..a}, active-low: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).

## Timing
- Output latency: one cycle from the dig/dsp state to an/seg/dp.
- After rst_n rises:
  - First edge: an=4'b1110, showing digit 0 of dsp_val=0, so seg=7'h40.
  - Digit 0 stays active for REFRESH_DIV cycles, then digit 1, and so on. One frame = 4·REFRESH_DIV cycles.
- The first frame_tick occurs in cycle 4·REFRESH_DIV-1 after reset release, counting from cycle 0.
- Load-to-display latency: a loaded value first appears on the output register in the cycle after the next boundary, i.e. when digit 0 of the next frame is driven. Worst case is 4·REFRESH_DIV+1 cycles.
- Reset mid-frame: outputs return to reset values immediately (asynchronous). Any pending value is discarded.
- No glitch between digits: an and seg change on the same edge, both registered.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Digit k∈{1,2,3} is blanked when dsp_val nibbles k..3 are all zero.
  - Blanked means seg=7'h7F while an still selects the digit.
  - Digit 0 is never blanked.
  - dp is unaffected by blanking.
- LEADING_ZERO_BLANK_EN undefined: all four digits are always shown, including leading zeros.

## Test plan
- Reset, REFRESH_DIV=4:
  - rst_n=0 → an=F, seg=7F, dp=1.
  - After release, an cycles E,D,B,7 every 4 cycles with seg=40.
  - frame_tick is high in cycle 15.
- Mid-frame load: load value=16'h1A3F, carry=1 at cycle 5 (dig=1).
  - The current frame still shows 0 on every digit.
  - Next frame shows seg 0E, 30, 08, 79 for digits 0–3, with dp=0 only while an=7.
- Double load before the boundary: 16'h1111, then 16'h2222 → only 2222 is displayed (seg=24 on every digit); 1111 is never shown.
- Load on the boundary cycle (dig=3, presc=3) with 16'hBEEF → applied immediately; the next digit-0 output is seg=0E.
- Reset mid-operation: load 16'hFFFF, then rst_n pulse low for 1 cycle → outputs go to reset values immediately, and after release digits show 0.
- With LEADING_ZERO_BLANK_EN, value=16'h0050:
  - Digits 3 and 2 show seg=7F.
  - Digit 1 shows 12; digit 0 shows 40.
  - value=0 shows only digit 0 as 40.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit common-anode seven-segment driver with frame-aligned value updates.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        carry,
    input  logic        load,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] presc;
    logic [1:0]    dig;
    logic [15:0]   sh_val;
    logic          sh_cy;
    logic [15:0]   dsp_val;
    logic          dsp_cy;
    logic          pending;
    logic          presc_last;
    logic          boundary;
    logic [3:0]    nib;
    logic          blank;

    assign presc_last = (presc == PRESC_LAST);
    assign boundary   = presc_last && (dig == 2'd3);
    assign frame_tick = boundary;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h40;
            4'h1:    hex7 = 7'h79;
            4'h2:    hex7 = 7'h24;
            4'h3:    hex7 = 7'h30;
            4'h4:    hex7 = 7'h19;
            4'h5:    hex7 = 7'h12;
            4'h6:    hex7 = 7'h02;
            4'h7:    hex7 = 7'h78;
            4'h8:    hex7 = 7'h00;
            4'h9:    hex7 = 7'h10;
            4'hA:    hex7 = 7'h08;
            4'hB:    hex7 = 7'h03;
            4'hC:    hex7 = 7'h46;
            4'hD:    hex7 = 7'h21;
            4'hE:    hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        nib = 4'h0;
        case (dig)
            2'd0:    nib = dsp_val[3:0];
            2'd1:    nib = dsp_val[7:4];
            2'd2:    nib = dsp_val[11:8];
            default: nib = dsp_val[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        blank = 1'b0;
        case (dig)
            2'd1:    blank = (dsp_val[15:4] == 12'h000);
            2'd2:    blank = (dsp_val[15:8] == 8'h00);
            2'd3:    blank = (dsp_val[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
    end
`else
    assign blank = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
            dig   <= 2'd0;
        end else begin
            presc <= presc_last ? '0 : presc + 1'b1;
            if (presc_last) dig <= dig + 2'd1;
        end
    end

    // A load on the boundary goes straight to the display so it is not deferred a whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_val  <= 16'h0000;
            sh_cy   <= 1'b0;
            dsp_val <= 16'h0000;
            dsp_cy  <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (load) begin
                sh_val <= value;
                sh_cy  <= carry;
            end
            if (boundary) begin
                pending <= 1'b0;
                if (load) begin
                    dsp_val <= value;
                    dsp_cy  <= carry;
                end else if (pending) begin
                    dsp_val <= sh_val;
                    dsp_cy  <= sh_cy;
                end
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= ~(4'b0001 << dig);
            seg <= blank ? 7'h7F : hex7(nib);
            dp  <= ~(dsp_cy & (dig == 2'd3));
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with REFRESH_DIV=4 (16-cycle frames).
// Build with LEADING_ZERO_BLANK_EN defined to cover the blanking option.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        carry = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    seg_scan_driver #(.REFRESH_DIV(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .value(value),
        .carry(carry),
        .load(load),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Called at a negedge; asserts reset, confirms it acts immediately, releases on the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        load  = 1'b0;
        #1;
        chk("rst_an", {12'h0, an}, 16'h000F);
        chk("rst_seg", {9'h0, seg}, 16'h007F);
        chk("rst_dp", {15'h0, dp}, 16'h0001);
        chk("rst_tick", {15'h0, frame_tick}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // Advance n cycles; after edge k outputs show the digit active in cycle k-1.
    task automatic run(input int n, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input logic dp3);
        int d;
        logic [3:0] an_exp;
        logic [6:0] s_exp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            load = 1'b0;
            cyc++;
            d = ((cyc - 1) / 4) % 4;
            an_exp = ~(4'b0001 << d);
            case (d)
                0:       s_exp = s0;
                1:       s_exp = s1;
                2:       s_exp = s2;
                default: s_exp = s3;
            endcase
            chk("an", {12'h0, an}, {12'h0, an_exp});
            chk("seg", {9'h0, seg}, {9'h0, s_exp});
            chk("dp", {15'h0, dp}, {15'h0, ~(dp3 && d == 3)});
            chk("tick", {15'h0, frame_tick}, {15'h0, (cyc % 16) == 15});
        end
    endtask

    task automatic put(input logic [15:0] v, input logic c);
        value = v;
        carry = c;
        load  = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        run(32, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);

        // load mid-frame at cycle 5
        do_reset();
        run(5, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        put(16'h1A3F, 1'b1);
        run(11, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        run(32, 7'h0E, 7'h30, 7'h08, 7'h79, 1'b1);

        // double load: only the last one is shown
        do_reset();
        run(2, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        put(16'h1111, 1'b0);
        run(6, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        put(16'h2222, 1'b0);
        run(8, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        run(16, 7'h24, 7'h24, 7'h24, 7'h24, 1'b0);

        // load on the boundary cycle takes effect for the next frame
        do_reset();
        run(15, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        put(16'hBEEF, 1'b0);
        run(1, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        run(16, 7'h0E, 7'h06, 7'h06, 7'h03, 1'b0);

        // reset mid-operation clears the displayed value
        do_reset();
        run(2, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        put(16'hFFFF, 1'b1);
        run(14, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        run(6, 7'h0E, 7'h0E, 7'h0E, 7'h0E, 1'b1);
        do_reset();
        run(32, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);

        // leading zeros
        do_reset();
        put(16'h0050, 1'b0);
        run(16, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
        put(16'h0000, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
        run(16, 7'h40, 7'h12, 7'h7F, 7'h7F, 1'b0);
        run(16, 7'h40, 7'h7F, 7'h7F, 7'h7F, 1'b0);
`else
        run(16, 7'h40, 7'h12, 7'h40, 7'h40, 1'b0);
        run(16, 7'h40, 7'h40, 7'h40, 7'h40, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
